turn_signal_ctrl: RTL and testbench
===================================

# turn_signal_ctrl

Sequencing controller for the Thunderbird tail-light lamp FSM on the DE2-115. It runs from the 50 MHz board clock and synchronizes the raw hazard/left/right switches. It arbitrates them into one clean, mutually exclusive command and generates the one-cycle step enable that advances the lamp FSM. Commands change only on step boundaries, so the lamp FSM never sees a request change mid-step or a conflicting request.

## Interface

Parameters:
- TICK_DIV, 50_000_000, clk_50mhz cycles per step (≥2)
- TURN_STEPS, 4, steps per left/right sequence (2..4)
- HAZ_STEPS, 2, steps per hazard sequence (2..4)

Ports:
- clk_50mhz  in  1  board clock; sole clock
- reset_n  in  1  asynchronous, active-low reset
- haz_sw  in  1  hazard switch, asynchronous
- left_sw  in  1  left-turn switch, asynchronous
- right_sw  in  1  right-turn switch, asynchronous
- step  out  1  one-cycle advance pulse to lamp FSM
- haz_cmd  out  1  hazard command, registered
- left_cmd  out  1  left command, registered
- right_cmd  out  1  right command, registered
- phase  out  2  step index within current sequence
- busy  out  1  high whenever a sequence is active

## Operation

- Synchronizers: two flops per switch. s_haz, s_left and s_right are the second-stage outputs.
- Request decode, from synchronized values:
  - hreq = s_haz | (s_left & s_right)
  - lreq = s_left & ~s_right & ~s_haz
  - rreq = s_right & ~s_left & ~s_haz
- Tick counter:
  - Free-running, counts 0..TICK_DIV-1, then wraps to 0.
  - step is registered and is 1 for exactly the cycle after the counter reads TICK_DIV-1.
- FSM states: IDLE, LEFT, RIGHT, HAZ. Register phase is 2 bits wide. State and phase update only on cycles where the tick condition fires; all other cycles hold.
- Arbitration, priority hazard > left > right:
  - hreq → HAZ, phase 0
  - else lreq → LEFT, phase 0
  - else rreq → RIGHT, phase 0
  - else IDLE, phase 0
- IDLE on tick: arbitrate.
- LEFT/RIGHT on tick:
  - hreq → HAZ, phase 0 (preemption)
  - else phase == TURN_STEPS-1 → arbitrate
  - else phase + 1
  - A withdrawn turn request does not abort the sequence; it runs to its last phase.
  - Reversing direction mid-sequence takes effect only at sequence end.
- HAZ on tick:
  - phase == HAZ_STEPS-1 → arbitrate
  - else phase + 1
  - Nothing preempts hazard.
- Outputs:
  - haz_cmd, left_cmd and right_cmd are registered decodes of state; at most one is high.
  - busy = (state != IDLE).
  - phase is driven directly from its register.

## Timing

- Asynchronous reset: all outputs 0, state IDLE, phase 0, tick counter 0, synchronizer flops 0. The effect is immediate, including mid-sequence.
- After reset release, the tick counter reaches TICK_DIV-1 at cycle TICK_DIV-1, so step first pulses at cycle TICK_DIV. It then pulses every TICK_DIV cycles.
- Switch-to-synchronized latency: 2 cycles.
- A request is accepted at the first tick condition at which it is synchronized. The cmd, phase and busy change appears on the same cycle as the corresponding step pulse, so the lamp FSM samples the new command together with step.
- Worst-case switch-to-command latency: 2 + TICK_DIV cycles.
- A switch glitch shorter than one clock may be missed or accepted. Either outcome is legal, but an accepted request always yields a full sequence (except turn preemption by hazard).
- With a request held continuously, sequences repeat back to back with no IDLE gap. Phase wraps TURN_STEPS-1 → 0 (or HAZ_STEPS-1 → 0).

## Test plan

All scenarios use TICK_DIV=4, TURN_STEPS=4, HAZ_STEPS=2.

- Reset, no switches → all outputs 0; step high at cycles 4, 8, 12 after release; busy stays 0.
- left_sw held from cycle 0 → left_cmd=1 at the first step; phase 0,1,2,3,0,1… on successive steps; haz_cmd=right_cmd=0 throughout.
- left_sw dropped while phase=1 → phase 2, then 3, then IDLE at the next step; left_cmd falls on the step after phase 3.
- right sequence at phase 1, then haz_sw asserted → at the next step after synchronization: right_cmd=0, haz_cmd=1, phase=0; phase then alternates 0,1 while held.
- left_sw and right_sw asserted in the same cycle, haz_sw=0 → haz_cmd=1, left_cmd=right_cmd=0.
- reset_n pulsed low mid-HAZ (phase=1, not aligned to clock) → outputs 0 immediately; after release, step pulses again after 4 cycles; with haz_sw still held, haz_cmd=1 at that first step.

Source files
------------

// File: rtl/turn_signal_ctrl.sv
// rtl/turn_signal_ctrl.sv - switch sync, request arbitration and step sequencing for the tail-light lamp FSM
module turn_signal_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int TURN_STEPS = 4,
    parameter int HAZ_STEPS  = 2
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       haz_sw,
    input  logic       left_sw,
    input  logic       right_sw,
    output logic       step,
    output logic       haz_cmd,
    output logic       left_cmd,
    output logic       right_cmd,
    output logic [1:0] phase,
    output logic       busy
);

    localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [1:0]    TURN_LAST = 2'(TURN_STEPS - 1);
    localparam logic [1:0]    HAZ_LAST  = 2'(HAZ_STEPS - 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

    // bit order in the synchronizer vectors: {haz, left, right}
    logic [2:0]    sync1, sync2;
    logic          s_haz, s_left, s_right;
    logic          hreq, lreq, rreq;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    state_t        state, next_state;
    logic [1:0]    phase_q, next_phase;

    // Two-flop synchronizers for the raw switches
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {haz_sw, left_sw, right_sw};
            sync2 <= sync1;
        end
    end

    assign s_haz   = sync2[2];
    assign s_left  = sync2[1];
    assign s_right = sync2[0];

    // Both turn switches together are treated as a hazard request
    assign hreq = s_haz | (s_left & s_right);
    assign lreq = s_left & ~s_right & ~s_haz;
    assign rreq = s_right & ~s_left & ~s_haz;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running step divider; step is the registered tick condition
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            step     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
            step     <= tick;
        end
    end

    function automatic state_t arbitrate(input logic h, input logic l, input logic r);
        if (h)      return HAZ;
        else if (l) return LEFT;
        else if (r) return RIGHT;
        else        return IDLE;
    endfunction

    // State and phase register
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            phase_q <= 2'd0;
        end else begin
            state   <= next_state;
            phase_q <= next_phase;
        end
    end

    // Next state: only the tick cycle may move the sequence
    always_comb begin
        next_state = state;
        next_phase = phase_q;
        if (tick) begin
            case (state)
                IDLE: begin
                    next_state = arbitrate(hreq, lreq, rreq);
                    next_phase = 2'd0;
                end
                LEFT, RIGHT: begin
                    if (hreq) begin
                        next_state = HAZ;
                        next_phase = 2'd0;
                    end else if (phase_q == TURN_LAST) begin
                        next_state = arbitrate(hreq, lreq, rreq);
                        next_phase = 2'd0;
                    end else begin
                        next_phase = phase_q + 2'd1;
                    end
                end
                HAZ: begin
                    if (phase_q == HAZ_LAST) begin
                        next_state = arbitrate(hreq, lreq, rreq);
                        next_phase = 2'd0;
                    end else begin
                        next_phase = phase_q + 2'd1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_phase = 2'd0;
                end
            endcase
        end
    end

    // Command registers load from next state so they change together with step
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            haz_cmd   <= 1'b0;
            left_cmd  <= 1'b0;
            right_cmd <= 1'b0;
        end else begin
            haz_cmd   <= (next_state == HAZ);
            left_cmd  <= (next_state == LEFT);
            right_cmd <= (next_state == RIGHT);
        end
    end

    // Status outputs straight from the state/phase registers
    always_comb begin
        busy  = (state != IDLE);
        phase = phase_q;
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// tb/tb_turn_signal_ctrl.sv - randomized and directed checks of turn_signal_ctrl against a sequence model
module tb_turn_signal_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int TURN_STEPS = 4;
    localparam int HAZ_STEPS  = 2;

    localparam int K_IDLE  = 0;
    localparam int K_LEFT  = 1;
    localparam int K_RIGHT = 2;
    localparam int K_HAZ   = 3;

    logic       clk_50mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic       haz_sw    = 1'b0;
    logic       left_sw   = 1'b0;
    logic       right_sw  = 1'b0;
    logic       step, haz_cmd, left_cmd, right_cmd, busy;
    logic [1:0] phase;

    int assertions = 0;
    int failures   = 0;

    // reference model: which sequence is running and how far along it is
    int       m_cnt;
    int       m_kind;
    int       m_pos;
    bit       m_step;
    bit [2:0] m_s1, m_s2;

    turn_signal_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .TURN_STEPS(TURN_STEPS),
        .HAZ_STEPS (HAZ_STEPS)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .reset_n  (reset_n),
        .haz_sw   (haz_sw),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .step     (step),
        .haz_cmd  (haz_cmd),
        .left_cmd (left_cmd),
        .right_cmd(right_cmd),
        .phase    (phase),
        .busy     (busy)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    function automatic int pick(input bit h, input bit l, input bit r);
        if (h) return K_HAZ;
        if (l) return K_LEFT;
        if (r) return K_RIGHT;
        return K_IDLE;
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [1:0] p;
        p = 2'(m_pos);
        return {m_step, m_kind == K_HAZ, m_kind == K_LEFT, m_kind == K_RIGHT, p, m_kind != K_IDLE};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {step, haz_cmd, left_cmd, right_cmd, phase, busy};
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_kind = K_IDLE;
        m_pos  = 0;
        m_step = 0;
        m_s1   = '0;
        m_s2   = '0;
    endtask

    task automatic model_update();
        bit h, l, r, both, tick;
        h    = m_s2[2];
        l    = m_s2[1];
        r    = m_s2[0];
        both = l & r;
        tick = (m_cnt == TICK_DIV - 1);
        if (tick) begin
            if (m_kind == K_IDLE) begin
                m_kind = pick(h | both, l & ~r & ~h, r & ~l & ~h);
                m_pos  = 0;
            end else if (m_kind == K_HAZ) begin
                if (m_pos == HAZ_STEPS - 1) begin
                    m_kind = pick(h | both, l & ~r & ~h, r & ~l & ~h);
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end else if (h | both) begin
                m_kind = K_HAZ;
                m_pos  = 0;
            end else if (m_pos == TURN_STEPS - 1) begin
                m_kind = pick(1'b0, l & ~r, r & ~l);
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        m_step = tick;
        m_cnt  = (m_cnt + 1) % TICK_DIV;
        m_s2   = m_s1;
        m_s1   = {haz_sw, left_sw, right_sw};
    endtask

    task automatic clk_cycle();
        @(posedge clk_50mhz);
        model_update();
        @(negedge clk_50mhz);
    endtask

    task automatic do_reset();
        @(negedge clk_50mhz);
        reset_n = 1'b0;
        #2;
        @(negedge clk_50mhz);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        haz_sw = 0; left_sw = 0; right_sw = 0;
        do_reset();
        assertions++;
        if (dut_vec() !== 7'd0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", dut_vec(), 7'd0);
        end
        for (int c = 1; c <= 13; c++) begin
            clk_cycle();
            assertions++;
            if (step !== ((c % TICK_DIV) == 0) || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_step cycle %0d: step=%b busy=%b expected step=%b busy=0",
                         c, step, busy, (c % TICK_DIV) == 0);
            end
        end
    endtask

    task automatic test_left_hold();
        do_reset();
        left_sw = 1;
        for (int c = 1; c <= 24; c++) begin
            clk_cycle();
            assertions++;
            if (dut_vec() !== exp_vec() || haz_cmd !== 1'b0 || right_cmd !== 1'b0) begin
                failures++;
                $display("FAIL left_hold cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        assertions++;
        if (left_cmd !== 1'b1) begin
            failures++;
            $display("FAIL left_hold_cmd: got %b expected 1", left_cmd);
        end
    endtask

    task automatic test_left_drop();
        int n = 0;
        while (!(m_kind == K_LEFT && m_pos == 1) && n < 40) begin
            clk_cycle();
            n++;
        end
        assertions++;
        if (n >= 40) begin
            failures++;
            $display("FAIL left_drop_wait: phase 1 not reached within 40 cycles, phase=%0d", phase);
        end
        left_sw = 0;
        for (int c = 1; c <= 20; c++) begin
            clk_cycle();
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL left_drop cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        assertions++;
        if (busy !== 1'b0 || left_cmd !== 1'b0) begin
            failures++;
            $display("FAIL left_drop_end: busy=%b left_cmd=%b expected 0 0", busy, left_cmd);
        end
    endtask

    task automatic test_preempt();
        int n = 0;
        do_reset();
        right_sw = 1;
        while (!(m_kind == K_RIGHT && m_pos == 1) && n < 40) begin
            clk_cycle();
            n++;
        end
        assertions++;
        if (n >= 40) begin
            failures++;
            $display("FAIL preempt_wait: right phase 1 not reached, phase=%0d", phase);
        end
        haz_sw = 1;
        for (int c = 1; c <= 20; c++) begin
            clk_cycle();
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL preempt cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        assertions++;
        if (haz_cmd !== 1'b1 || right_cmd !== 1'b0) begin
            failures++;
            $display("FAIL preempt_end: haz_cmd=%b right_cmd=%b expected 1 0", haz_cmd, right_cmd);
        end
        haz_sw = 0; right_sw = 0;
    endtask

    task automatic test_both_turns();
        do_reset();
        left_sw = 1; right_sw = 1;
        for (int c = 1; c <= 12; c++) begin
            clk_cycle();
            assertions++;
            if (dut_vec() !== exp_vec() || left_cmd !== 1'b0 || right_cmd !== 1'b0) begin
                failures++;
                $display("FAIL both_turns cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        assertions++;
        if (haz_cmd !== 1'b1) begin
            failures++;
            $display("FAIL both_turns_haz: got %b expected 1", haz_cmd);
        end
        left_sw = 0; right_sw = 0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        haz_sw = 1;
        while (!(m_kind == K_HAZ && m_pos == 1) && n < 40) begin
            clk_cycle();
            n++;
        end
        assertions++;
        if (n >= 40) begin
            failures++;
            $display("FAIL async_reset_wait: hazard phase 1 not reached, phase=%0d", phase);
        end
        #2 reset_n = 1'b0;
        #1;
        assertions++;
        if (dut_vec() !== 7'd0) begin
            failures++;
            $display("FAIL async_reset_immediate: got %b expected %b", dut_vec(), 7'd0);
        end
        @(posedge clk_50mhz);
        #2 reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 10; c++) begin
            clk_cycle();
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL async_reset_after cycle %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            if (c == TICK_DIV) begin
                assertions++;
                if (step !== 1'b1 || haz_cmd !== 1'b1 || phase !== 2'd0) begin
                    failures++;
                    $display("FAIL async_reset_first_step: step=%b haz_cmd=%b phase=%0d expected 1 1 0",
                             step, haz_cmd, phase);
                end
            end
        end
        haz_sw = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: haz_sw   = ~haz_sw;
                    1: left_sw  = ~left_sw;
                    default: right_sw = ~right_sw;
                endcase
            end
            clk_cycle();
            assertions++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle %0d: got %b expected %b (sw=%b%b%b)",
                         c, dut_vec(), exp_vec(), haz_sw, left_sw, right_sw);
            end
        end
        haz_sw = 0; left_sw = 0; right_sw = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_left_hold();
        test_left_drop();
        test_preempt();
        test_both_turns();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
